// File: rtl/branch_predict_unit.sv
// EX-stage branch resolver with a direct-mapped 2-bit counter predictor and a one-cycle mispredict flush.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_predict_unit #(
  parameter int PC_W   = 32,
  parameter int IDX_W  = 4,
  parameter int STAT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [2:0]      ex_branch,
  input  logic            ex_zero,
  input  logic            ex_neg,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_pred_taken,
  output logic            ex_taken,
  output logic            flush,
  output logic            redirect_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
`endif
);

  localparam int DEPTH = 2 ** IDX_W;

  logic [1:0]       ctr [DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             cond;
  logic             mode_ok;
  logic             live;
  logic             mispredict;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  assign if_idx     = if_pc[IDX_W+1:2];
  assign ex_idx     = ex_pc[IDX_W+1:2];
  // No bypass: a same-cycle update to this index shows up only on the next cycle.
  assign pred_taken = ctr[if_idx][1];

  always_comb begin
    cond    = 1'b0;
    mode_ok = 1'b1;
    case (ex_branch)
      3'b001:  cond = ex_zero;
      3'b010:  cond = !ex_zero;
      3'b011:  cond = ex_neg | ex_zero;
      3'b100:  cond = !ex_neg & !ex_zero;
      3'b101:  cond = ex_neg;
      3'b110:  cond = !ex_neg;
      default: mode_ok = 1'b0;
    endcase
  end

  // The cycle after a flush holds a wrong-path instruction, so it is never live.
  assign live       = ex_valid & mode_ok & !flush;
  assign ex_taken   = live & cond;
  assign mispredict = live & (ex_taken != ex_pred_taken);

  // Update / flush stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= 2'b01;
      flush          <= 1'b0;
      redirect_taken <= 1'b0;
    end else begin
      if (live) ctr[ex_idx] <= ex_taken ? sat_inc2(ctr[ex_idx]) : sat_dec2(ctr[ex_idx]);
      flush <= mispredict;
      if (mispredict) redirect_taken <= ex_taken;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0], ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

`ifdef BRANCH_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc_stat(input logic [STAT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Statistics stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (live)       stat_branches    <= sat_inc_stat(stat_branches);
      if (mispredict) stat_mispredicts <= sat_inc_stat(stat_mispredicts);
    end
  end
`else
  logic [STAT_W-1:0] unused_stat;
  assign unused_stat = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: mode truth table plus hand-written flush, alias and reset sequences.
module tb_branch_predict_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [2:0]  ex_branch;
  logic        ex_zero;
  logic        ex_neg;
  logic [31:0] ex_pc;
  logic        ex_pred_taken;
  logic        ex_taken;
  logic        flush;
  logic        redirect_taken;
`ifdef BRANCH_STATS_EN
  logic [15:0] stat_branches;
  logic [15:0] stat_mispredicts;
`endif

  int n_total = 0;
  int n_pass  = 0;

  branch_predict_unit #(.PC_W(32), .IDX_W(4), .STAT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_zero(ex_zero), .ex_neg(ex_neg),
    .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
    .flush(flush), .redirect_taken(redirect_taken)
`ifdef BRANCH_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] mode;
    logic       zero;
    logic       neg;
    logic       exp_taken;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] m, input logic z, input logic n,
                       input logic [31:0] pc, input logic p);
    ex_valid = v; ex_branch = m; ex_zero = z; ex_neg = n; ex_pc = pc; ex_pred_taken = p;
  endtask

  initial begin
    // Truth table per mode over {zero,neg} = 00,01,10,11 (bit index = {zero,neg}).
    logic [3:0] tt [8];
    tt[0] = 4'b0000; tt[1] = 4'b1100; tt[2] = 4'b0011; tt[3] = 4'b1110;
    tt[4] = 4'b0001; tt[5] = 4'b1010; tt[6] = 4'b0101; tt[7] = 4'b0000;
    for (int m = 0; m < 8; m++)
      for (int c = 0; c < 4; c++) begin
        vecs[m*4+c].mode      = 3'(m);
        vecs[m*4+c].zero      = c[1];
        vecs[m*4+c].neg       = c[0];
        vecs[m*4+c].exp_taken = tt[m][c];
      end

    rst_n = 1'b0;
    if_pc = '0;
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
    #12 rst_n = 1'b1;
    cyc();

    // Reset state: every counter weakly not-taken.
    for (int i = 0; i < 16; i++) begin
      if_pc = 32'(i) << 2;
      #1 check($sformatf("reset_pred_idx%0d", i), {31'b0, pred_taken}, 32'h0);
    end
    check("reset_flush", {31'b0, flush}, 32'h0);
    check("reset_redirect", {31'b0, redirect_taken}, 32'h0);

    // Three beq at 0x40: second is masked by the flush from the first.
    drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h40, 1'b0);
    #1 check("beq1_taken", {31'b0, ex_taken}, 32'h1);
    cyc();
    check("beq1_flush", {31'b0, flush}, 32'h1);
    check("beq1_redirect", {31'b0, redirect_taken}, 32'h1);
    check("beq2_masked", {31'b0, ex_taken}, 32'h0);
    cyc();
    check("beq2_noflush", {31'b0, flush}, 32'h0);
    check("beq3_taken", {31'b0, ex_taken}, 32'h1);
    cyc();
    check("beq3_flush", {31'b0, flush}, 32'h1);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
    if_pc = 32'h40;
    #1 check("beq_ctr_11", {31'b0, pred_taken}, 32'h1);
    cyc();
    check("beq_flush_drop", {31'b0, flush}, 32'h0);

    // All modes and flag combinations, prediction always correct.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].zero, vecs[i].neg, 32'h3C, vecs[i].exp_taken);
      #1 check($sformatf("mode%0d_z%0d_n%0d_taken", vecs[i].mode, vecs[i].zero, vecs[i].neg),
               {31'b0, ex_taken}, {31'b0, vecs[i].exp_taken});
      cyc();
      check($sformatf("mode%0d_z%0d_n%0d_flush", vecs[i].mode, vecs[i].zero, vecs[i].neg),
            {31'b0, flush}, 32'h0);
    end

    // Back-to-back mispredicts: the second one is masked.
    drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h24, 1'b1);
    #1 check("mp1_taken", {31'b0, ex_taken}, 32'h0);
    cyc();
    check("mp1_flush", {31'b0, flush}, 32'h1);
    check("mp1_redirect", {31'b0, redirect_taken}, 32'h0);
    drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h28, 1'b0);
    #1 check("mp2_masked", {31'b0, ex_taken}, 32'h0);
    cyc();
    check("mp2_noflush", {31'b0, flush}, 32'h0);
    check("mp2_redirect_hold", {31'b0, redirect_taken}, 32'h0);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
    if_pc = 32'h28;
    #1 check("mp2_ctr_unchanged", {31'b0, pred_taken}, 32'h0);
    if_pc = 32'h24;
    #1 check("mp1_ctr_dec", {31'b0, pred_taken}, 32'h0);

    // Aliasing: 0x80 and 0x40 share index 0 (currently 11).
    drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h80, 1'b0);
    cyc();
    drive(1'b1, 3'b001, 1'b0, 1'b0, 32'h40, 1'b0);
    if_pc = 32'h40;
    #1 check("alias_old_value", {31'b0, pred_taken}, 32'h1);
    cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
    #1 check("alias_new_value", {31'b0, pred_taken}, 32'h0);
    check("alias_noflush", {31'b0, flush}, 32'h0);

    // Asynchronous reset mid-cycle, then release with a mispredict waiting in EX.
    drive(1'b1, 3'b110, 1'b0, 1'b0, 32'h14, 1'b1);
    cyc();
    cyc();
    drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h14, 1'b0);
    if_pc = 32'h14;
    #1 check("pre_reset_pred", {31'b0, pred_taken}, 32'h1);
    cyc();
    check("pre_reset_flush", {31'b0, flush}, 32'h1);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check("async_rst_flush", {31'b0, flush}, 32'h0);
    check("async_rst_redirect", {31'b0, redirect_taken}, 32'h0);
    check("async_rst_pred", {31'b0, pred_taken}, 32'h0);
    drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h14, 1'b0);
    #2 rst_n = 1'b1;
    cyc();
    check("post_rst_flush", {31'b0, flush}, 32'h1);
    check("post_rst_redirect", {31'b0, redirect_taken}, 32'h1);
    check("post_rst_pred", {31'b0, pred_taken}, 32'h1);
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
    cyc();
    check("post_rst_flush_drop", {31'b0, flush}, 32'h0);

`ifdef BRANCH_STATS_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h30, 1'b1); cyc();
    drive(1'b1, 3'b001, 1'b1, 1'b0, 32'h30, 1'b0); cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);  cyc();
    drive(1'b1, 3'b010, 1'b1, 1'b0, 32'h30, 1'b0); cyc();
    drive(1'b1, 3'b101, 1'b0, 1'b1, 32'h30, 1'b0); cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);  cyc();
    drive(1'b1, 3'b110, 1'b0, 1'b0, 32'h30, 1'b1); cyc();
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);  cyc();
    check("stat_branches", 32'(stat_branches), 32'd5);
    check("stat_mispredicts", 32'(stat_mispredicts), 32'd2);
    #2 rst_n = 1'b0;
    #1 check("stat_branches_rst", 32'(stat_branches), 32'd0);
    check("stat_mispredicts_rst", 32'(stat_mispredicts), 32'd0);
    rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
